// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - register-file write port arbiter: writeback first, long-latency results via in-order FIFO
module regfile_write_arbiter #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wb_we_i,
    input  logic [4:0]        wb_reg_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              lu_issue_i,
    input  logic [4:0]        lu_issue_reg_i,
    input  logic              lu_valid_i,
    input  logic [4:0]        lu_reg_i,
    input  logic [DATA_W-1:0] lu_data_i,
    output logic              lu_ready_o,
    output logic              rf_we_o,
    output logic [4:0]        rf_addr_o,
    output logic [DATA_W-1:0] rf_data_o,
    output logic [31:0]       busy_o,
    output logic              fifo_full_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [4:0]        r_fifo_reg  [DEPTH];
    logic [DATA_W-1:0] r_fifo_data [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [31:0]       r_busy;

    logic              w_wb_act;
    logic              w_full;
    logic              w_empty;
    logic              w_sel;
    logic              w_pop;
    logic              w_bypass;
    logic              w_push;
    logic [4:0]        w_sel_reg;
    logic [DATA_W-1:0] w_sel_data;
    logic [31:0]       w_busy_next;

    assign w_wb_act = wb_we_i && (wb_reg_i != 5'd0);
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_empty  = (r_count == '0);

    always_comb begin
        w_sel      = 1'b0;
        w_pop      = 1'b0;
        w_bypass   = 1'b0;
        w_sel_reg  = 5'd0;
        w_sel_data = '0;
        if (w_wb_act) begin
            w_sel      = 1'b1;
            w_sel_reg  = wb_reg_i;
            w_sel_data = wb_data_i;
        end else if (!w_empty) begin
            w_sel      = 1'b1;
            w_pop      = 1'b1;
            w_sel_reg  = r_fifo_reg[r_rd_ptr];
            w_sel_data = r_fifo_data[r_rd_ptr];
        end else if (lu_valid_i) begin
            w_sel      = 1'b1;
            w_bypass   = 1'b1;
            w_sel_reg  = lu_reg_i;
            w_sel_data = lu_data_i;
        end
    end

    // Bypass only happens with an empty FIFO, so ready is implied there.
    assign w_push = lu_valid_i && !w_full && !w_bypass;

    assign rf_we_o     = w_sel && (w_sel_reg != 5'd0);
    assign rf_addr_o   = w_sel_reg;
    assign rf_data_o   = w_sel_data;
    assign lu_ready_o  = !w_full;
    assign fifo_full_o = w_full;
    assign busy_o      = r_busy;

    // Issue is applied after the clear so a fresh op keeps its bit.
    always_comb begin
        w_busy_next = r_busy;
        if (w_pop || w_bypass) begin
            w_busy_next[w_sel_reg] = 1'b0;
        end
        if (lu_issue_i) begin
            w_busy_next[lu_issue_reg_i] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_busy   <= '0;
        end else begin
            r_busy <= w_busy_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_reg[r_wr_ptr]  <= lu_reg_i;
            r_fifo_data[r_wr_ptr] <= lu_data_i;
        end
    end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port between the pipeline writeback stage and a long-latency result source (multiply/divide unit or similar) that returns results out of band. Writeback-stage writes always win. Displaced long-latency results are held in a small in-order FIFO and drained on idle writeback cycles. A 32-entry busy scoreboard tracks destinations with outstanding long-latency results, and the hazard unit consumes it.

## Interface
- `DEPTH`, 2 — long-latency result FIFO entries; power of two, ≥2
- `DATA_W`, 32 — result data width

- `clk_i`  in  1  clock; all state updates on the rising edge
- `rst_ni`  in  1  asynchronous, active-low reset
- `wb_we_i`  in  1  writeback stage register write enable
- `wb_reg_i`  in  5  writeback destination register
- `wb_data_i`  in  DATA_W  writeback result
- `lu_issue_i`  in  1  long-latency op issued this cycle
- `lu_issue_reg_i`  in  5  destination of the issued op
- `lu_valid_i`  in  1  long-latency result offered
- `lu_reg_i`  in  5  result destination
- `lu_data_i`  in  DATA_W  result data
- `lu_ready_o`  out  1  result accepted when `lu_valid_i && lu_ready_o`
- `rf_we_o`  out  1  register-file write enable; combinational
- `rf_addr_o`  out  5  register-file write address
- `rf_data_o`  out  DATA_W  register-file write data
- `busy_o`  out  32  scoreboard; bit n = result for register n outstanding
- `fifo_full_o`  out  1  FIFO occupancy == DEPTH

## Operation
- **Effective writeback.** `wb_act = wb_we_i && wb_reg_i != 0`.
- **Source priority for the write port** (first match wins):
  1. `wb_act`: write `wb_reg_i`/`wb_data_i`.
  2. FIFO non-empty: write the FIFO head; pop at the edge.
  3. FIFO empty and `lu_valid_i`: bypass `lu_reg_i`/`lu_data_i` directly. The result is not enqueued.
  4. Otherwise `rf_we_o = 0`.
- **Enqueue.** An accepted result is enqueued unless it bypassed this cycle.
  - Push and pop may occur in the same cycle; occupancy is then unchanged.
  - The bypass path is legal only with an empty FIFO, which keeps long-latency results in order.
- **Ready.** `lu_ready_o = !fifo_full_o`. It does not depend on `lu_valid_i`.
  - At full, a same-cycle pop does not raise ready.
- **Register 0.** Any write to register 0 from either source drives `rf_we_o = 0`.
  - A register-0 result is still consumed: popped, or accepted-and-dropped on bypass.
- **FIFO pointers.** Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is a separate 0..DEPTH counter.
- **Scoreboard.**
  - Set: `lu_issue_i` with a nonzero destination sets bit `lu_issue_reg_i`.
  - Clear: a long-latency rf write (FIFO drain or bypass) clears bit `rf_addr_o`.
  - Set and clear of the same bit in one cycle: set wins, because a new op has issued.
  - Writeback-stage writes never touch the scoreboard. The hazard unit prevents writeback to a busy register.
  - `busy_o[0]` is always 0.
- **Reset.** Reset clears the FIFO and the scoreboard. In-flight results are discarded and not written.

## Timing
- **Reset values.**
  - `busy_o = 0`, `fifo_full_o = 0`, `lu_ready_o = 1`.
  - `rf_we_o` is 0 unless `wb_act` or the bypass condition holds combinationally.
  - `rf_addr_o`/`rf_data_o` follow the selected source and are 0 when none is selected.
- **Latency.**
  - Writeback path: zero cycles; port outputs are combinational from the inputs.
  - Bypass: zero cycles.
  - A queued result is written no earlier than the cycle after acceptance, on the first cycle with `!wb_act`.
- **Scoreboard visibility.**
  - A bit set by issue at edge k is visible from cycle k+1.
  - A bit cleared by an rf write at edge k is 0 from cycle k+1.
- **Handshake.** The transfer completes on the edge where `lu_valid_i && lu_ready_o`. The source holds its payload until then.
- **Throughput.**
  - Sustained `wb_act` starves the FIFO indefinitely. The pipeline must insert an idle writeback, or stall issue on `fifo_full_o`.
  - At most one rf write occurs per cycle.
- **Asynchronous reset mid-operation.**
  - Outputs take their reset values immediately on `rst_ni` falling.
  - Operation resumes on the first rising edge after `rst_ni` rises.

## Test plan
- **Bypass.** Idle writeback, FIFO empty, `lu_valid=1`, reg 5, data 0xAAAA0005 → same cycle `rf_we_o=1`, addr 5, data 0xAAAA0005. `busy_o[5]` (set two cycles earlier by issue) is 0 next cycle.
- **Conflict then drain.** `wb_we=1` reg 3 data 0x33 together with a result for reg 7 data 0x77 → the reg 3 write happens, and the reg 7 result is enqueued (occupancy 1). Next cycle with idle writeback → reg 7 data 0x77 is written and occupancy returns to 0.
- **Full FIFO.** `wb_act` held, 3 results offered for regs 8, 9, 10 → regs 8 and 9 are accepted, `lu_ready_o=0` and `fifo_full_o=1` hold reg 10. After writeback goes idle, rf writes occur in order 8, 9, 10 on consecutive cycles.
- **Scoreboard race.** Issue to reg 12 in the same cycle the previous reg-12 result drains → `busy_o[12]` remains 1. Issue with reg 0 → `busy_o` unchanged.
- **Register 0.** Writeback to reg 0 while the FIFO holds a reg 4 entry → the reg 4 entry drains that cycle. A reg-0 result offered is consumed with `rf_we_o=0`.
- **Reset mid-operation.** FIFO holds 2 entries and `busy_o = 0x00000300` → assert `rst_ni=0` between edges → immediately `busy_o=0`, `fifo_full_o=0`, `lu_ready_o=1`. No queued result is ever written.
